mayo_gf16_unpack: RTL and testbench

Downstream stage of the SHAKE core: once SHAKE has written its output into the shared BRAM, this block reads the packed bytes and expands each 4-bit GF(16) element into its own byte. The expanded vector goes to a second BRAM region for the MAYO arithmetic stages. It owns the BRAM port only between `en` and `done`. Addressing and port conventions match the SHAKE core, so both can share the BRAM behind a simple mux.

---
 rtl/mayo_gf16_unpack.sv | 157 +++++++++++++++
 tb/tb_mayo_gf16_unpack.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mayo_gf16_unpack.sv
// Expands packed GF(16) nibbles read from BRAM into one element per byte,
// written back to a second BRAM region through the shared SHAKE-style port.
module mayo_gf16_unpack #(
    parameter int unsigned C_BRAMSIZE = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [31:0]           ilen,
    input  logic [31:0]           read_adr,
    input  logic [31:0]           write_adr,
    output logic                  done,
    output logic                  busy,
    output logic                  o_control,
    output logic                  BRAMA_en,
    output logic [3:0]            BRAMA_we,
    output logic [C_BRAMSIZE:0]   BRAMA_addr,
    output logic [31:0]           BRAMA_din,
    input  logic [31:0]           BRAMA_dout
);

    localparam int unsigned AW = C_BRAMSIZE + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_WR0,
        S_WR1,
        S_FIN
    } state_e;

    state_e        state_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [31:0]   rem_q;
    logic [15:0]   hi_q;
    logic          done_q;
    logic          busy_q;
    logic          bram_en_q;
    logic [3:0]    bram_we_q;
    logic [AW-1:0] bram_addr_q;
    logic [31:0]   bram_din_q;

    logic [AW-1:0] rd_base;
    logic [AW-1:0] wr_base;
    logic [31:0]   rem_d;
    logic          last_wr_c;
    logic          unused_adr_bits;

    function automatic logic [15:0] expand_byte(input logic [7:0] b);
        return {4'h0, b[7:4], 4'h0, b[3:0]};
    endfunction

    assign rd_base   = {read_adr[AW-1:2], 2'b00};
    assign wr_base   = {write_adr[AW-1:2], 2'b00};
    assign rem_d     = (rem_q > 32'd4) ? rem_q - 32'd4 : 32'd0;
    assign last_wr_c = (state_q == S_WR1) || (rem_q <= 32'd2);

    assign unused_adr_bits = ^{read_adr[31:AW], read_adr[1:0],
                               write_adr[31:AW], write_adr[1:0]};

    // Only the upper two lanes are needed after LATCH; lanes 0-1 feed WR0 directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rem_q       <= '0;
            hi_q        <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= 4'h0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            done_q      <= 1'b0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= 4'h0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        rd_ptr_q <= rd_base;
                        wr_ptr_q <= wr_base;
                        rem_q    <= ilen;
                        busy_q   <= 1'b1;
                        if (ilen == 32'd0) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= S_READ;
                            bram_en_q   <= 1'b1;
                            bram_addr_q <= rd_base;
                        end
                    end
                end
                S_READ: state_q <= S_LATCH;
                S_LATCH: begin
                    hi_q        <= BRAMA_dout[31:16];
                    state_q     <= S_WR0;
                    bram_en_q   <= 1'b1;
                    bram_addr_q <= wr_ptr_q;
                    if (rem_q >= 32'd2) begin
                        bram_we_q  <= 4'b1111;
                        bram_din_q <= {expand_byte(BRAMA_dout[15:8]), expand_byte(BRAMA_dout[7:0])};
                    end else begin
                        bram_we_q  <= 4'b0011;
                        bram_din_q <= {16'h0, expand_byte(BRAMA_dout[7:0])};
                    end
                end
                S_WR0, S_WR1: begin
                    if (!last_wr_c) begin
                        state_q     <= S_WR1;
                        bram_en_q   <= 1'b1;
                        bram_addr_q <= wr_ptr_q + AW'(4);
                        if (rem_q >= 32'd4) begin
                            bram_we_q  <= 4'b1111;
                            bram_din_q <= {expand_byte(hi_q[15:8]), expand_byte(hi_q[7:0])};
                        end else begin
                            bram_we_q  <= 4'b0011;
                            bram_din_q <= {16'h0, expand_byte(hi_q[7:0])};
                        end
                    end else begin
                        rd_ptr_q <= rd_ptr_q + AW'(4);
                        wr_ptr_q <= wr_ptr_q + AW'(8);
                        rem_q    <= rem_d;
                        if (rem_d != 32'd0) begin
                            state_q     <= S_READ;
                            bram_en_q   <= 1'b1;
                            bram_addr_q <= rd_ptr_q + AW'(4);
                        end else begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done       = done_q;
    assign busy       = busy_q;
    assign o_control  = busy_q;
    assign BRAMA_en   = bram_en_q;
    assign BRAMA_we   = bram_we_q;
    assign BRAMA_addr = bram_addr_q;
    assign BRAMA_din  = bram_din_q;

endmodule

// File: tb/tb_mayo_gf16_unpack.sv
// Directed bench for mayo_gf16_unpack: BRAM read model plus a write scoreboard
// filled from a byte-level reference of the nibble expansion.
module tb_mayo_gf16_unpack;

    localparam int unsigned AW = 14;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    we;
        logic [31:0]   din;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [31:0]   ilen = '0;
    logic [31:0]   read_adr = '0;
    logic [31:0]   write_adr = '0;
    logic          done;
    logic          busy;
    logic          o_control;
    logic          BRAMA_en;
    logic [3:0]    BRAMA_we;
    logic [AW-1:0] BRAMA_addr;
    logic [31:0]   BRAMA_din;
    logic [31:0]   BRAMA_dout = '0;

    logic [31:0] mem [0:4095];
    wr_t         exp_q[$];
    int          total = 0;
    int          passed = 0;
    int          en_cnt = 0;

    mayo_gf16_unpack #(.C_BRAMSIZE(13)) dut (
        .clk(clk), .rst(rst), .en(en), .ilen(ilen), .read_adr(read_adr),
        .write_adr(write_adr), .done(done), .busy(busy), .o_control(o_control),
        .BRAMA_en(BRAMA_en), .BRAMA_we(BRAMA_we), .BRAMA_addr(BRAMA_addr),
        .BRAMA_din(BRAMA_din), .BRAMA_dout(BRAMA_dout)
    );

    always #5 clk = ~clk;

    // Read-only BRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (BRAMA_en && BRAMA_we == 4'h0)
            BRAMA_dout <= mem[BRAMA_addr[AW-1:2]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Every write strobe is matched in order against the scoreboard.
    always @(negedge clk) begin
        if (BRAMA_en) en_cnt++;
        if (BRAMA_en && BRAMA_we != 4'h0) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write_addr", 64'(BRAMA_addr), 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(BRAMA_addr), 64'(e.addr));
                chk("wr_we", 64'(BRAMA_we), 64'(e.we));
                chk("wr_din", 64'(BRAMA_din), 64'(e.din));
            end
        end
    end

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[AW-1:2]];
        return 8'(w >> (8 * a[1:0]));
    endfunction

    // Reference: output byte i is nibble (i%2) of input byte i/2; words packed from write_adr.
    task automatic push_expected(input int unsigned len, input logic [31:0] ra,
                                 input logic [31:0] wa, output int exp_done);
        int unsigned n;
        int unsigned r;
        n = 2 * len;
        for (int unsigned w = 0; w < (n + 3) / 4; w++) begin
            wr_t e;
            e.addr = AW'((wa & ~32'd3) + 4 * w);
            e.we   = 4'h0;
            e.din  = '0;
            for (int unsigned l = 0; l < 4; l++) begin
                int unsigned idx;
                logic [7:0]  b;
                idx = 4 * w + l;
                if (idx < n) begin
                    b = mem_byte((ra & ~32'd3) + idx / 2);
                    e.we[l] = 1'b1;
                    e.din[8*l +: 8] = {4'h0, (idx % 2 == 1) ? b[7:4] : b[3:0]};
                end
            end
            exp_q.push_back(e);
        end
        exp_done = 1;
        r = len;
        while (r > 0) begin
            exp_done += (r <= 2) ? 3 : 4;
            r -= (r > 4) ? 4 : r;
        end
    endtask

    task automatic run(input int unsigned len, input logic [31:0] ra,
                       input logic [31:0] wa, input bit dup);
        int j;
        int exp_done;
        int en0;
        push_expected(len, ra, wa, exp_done);
        en0 = en_cnt;
        @(negedge clk);
        en = 1'b1; ilen = len; read_adr = ra; write_adr = wa;
        @(negedge clk);
        en = 1'b0;
        j = 1;
        chk("busy_first_cycle", 64'(busy), 64'd1);
        while (!done && j < 300) begin
            if (dup && j == 2) begin
                en = 1'b1; ilen = 32'd8; read_adr = 32'd16; write_adr = 32'd200;
            end else begin
                en = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        en = 1'b0;
        chk("done_cycle", 64'(j), 64'(exp_done));
        chk("busy_ctrl_at_done", 64'({busy, o_control}), 64'b11);
        @(negedge clk);
        chk("done_busy_fall", 64'({done, busy, o_control, BRAMA_en}), 64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        if (len == 0) chk("no_bram_enable", 64'(en_cnt - en0), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int j;
        int dummy;
        bit saw_done;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[0] = 32'hD808EE98;
        mem[1] = 32'h38520EBA;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({done, busy, o_control, BRAMA_en, BRAMA_we, BRAMA_addr, BRAMA_din}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", 64'({done, busy, o_control, BRAMA_en, BRAMA_we, BRAMA_addr, BRAMA_din}), 64'd0);

        run(4, 32'd0, 32'd32, 1'b0);
        run(5, 32'd0, 32'd32, 1'b0);
        run(0, 32'd0, 32'd32, 1'b0);
        run(6, 32'd0, 32'd32, 1'b0);
        run(7, 32'd0, 32'd32, 1'b0);
        run(12, 32'd0, 32'd32, 1'b1);
        run(4, 32'd0, 32'h0000_3FFC, 1'b0);
        run(8, 32'h0000_3FFC, 32'd64, 1'b0);
        run(9, 32'h0000_0043, 32'hFFFF_0102, 1'b0);
        run($urandom_range(1, 24), 32'd256, 32'd1024, 1'b0);

        // Abort during WR0 of the second word of a 16-byte run.
        push_expected(16, 32'd0, 32'd512, dummy);
        @(negedge clk);
        en = 1'b1; ilen = 32'd16; read_adr = 32'd0; write_adr = 32'd512;
        @(negedge clk);
        en = 1'b0;
        j = 1;
        while (j < 7) begin
            @(negedge clk);
            j++;
        end
        chk("abort_in_wr0", 64'({BRAMA_en, BRAMA_we, BRAMA_addr}), 64'({1'b1, 4'hF, 14'd520}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", 64'({done, busy, o_control, BRAMA_en, BRAMA_we, BRAMA_addr, BRAMA_din}), 64'd0);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("no_done_after_abort", 64'(saw_done), 64'd0);
        chk("abort_write_count", 64'(exp_q.size()), 64'd5);
        exp_q.delete();

        run(4, 32'd0, 32'd32, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
